dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of every address port.
REQ-002 Parameter DATA_W, default 32, data width of every data port.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports are named clock and reset.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req0, req1  input  1 each  access request from requester 0 (CPU) and requester 1 (DMA/debug).
REQ-007 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN is high.
REQ-008 addr0, addr1  input  ADDR_W each  access address.
REQ-009 wdata0, wdata1  input  DATA_W each  write data.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse to the requester.
REQ-011 rdata0, rdata1  output  DATA_W each  registered read data; valid in the ack cycle.
REQ-012 mem_we  output  1  write strobe to the data memory.
REQ-013 mem_addr  output  ADDR_W  memory address.
REQ-014 mem_wdata  output  DATA_W  memory write data.
REQ-015 mem_rdata  input  DATA_W  combinational read data from the memory for mem_addr.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP; reset state is IDLE.
REQ-017 IDLE: if any reqN is high, the block SHALL latch the winner's id, we, addr and wdata and enter ACCESS on the next edge; otherwise it stays in IDLE.
REQ-018 Arbitration SHALL be round-robin: with one request, that requester wins; with both requests, the requester not granted last wins.
REQ-019 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 ACCESS lasts exactly one cycle: mem_addr and mem_wdata are driven from the latched values, and mem_we = latched we.
REQ-021 In ACCESS, for reads, mem_rdata SHALL be captured into the winner's rdata register at the closing edge; the non-winner's rdata register is unchanged.
REQ-022 RESP lasts exactly one cycle: ackN is high for the winner only, then the FSM returns to IDLE.
REQ-023 Latency SHALL be: request sampled at edge T, ACCESS in cycle T..T+1, ack in cycle T+1..T+2. Peak throughput is one access per 3 cycles.
REQ-024 Outside ACCESS, mem_we SHALL be 0. mem_addr and mem_wdata SHALL hold their last values.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle; each is high at most one cycle per grant.
REQ-026 A requester SHALL hold reqN and its payload until ackN. Deasserting reqN after the grant does not cancel the access; ack is still issued.
REQ-027 A requester still asserting reqN in the RESP cycle is treated as a new request in the following IDLE cycle.
REQ-028 Payload changes after the latch edge SHALL NOT affect the access in flight.
REQ-029 A write followed by a read to the same address SHALL return the written data, because the write completes before the next ACCESS.

Reset
REQ-030 When reset is high at an edge: the FSM goes to IDLE, mem_we = 0, ack0 = ack1 = 0, rdata0 = rdata1 = 0, mem_addr = 0, mem_wdata = 0, last-grant = 1.
REQ-031 Reset during ACCESS or RESP SHALL abort the transaction: no ack is issued. A write whose ACCESS cycle coincides with the reset edge is not guaranteed to reach memory.
REQ-032 While reset is held, requests are ignored. Arbitration resumes in the first cycle after reset deasserts.

Verification
REQ-033 Single read: memory[0x10] = 0xDEADBEEF; req0 = 1, we0 = 0, addr0 = 0x10 at edge 0 -> mem_addr = 0x10 in cycle 1, ack0 = 1 with rdata0 = 0xDEADBEEF in cycle 2, ack1 = 0 throughout.
REQ-034 Simultaneous requests after reset: req0 and req1 held high (reads, 0x4 and 0x8) -> ack0 first, ack1 three cycles later, then grants alternate 0, 1, 0, 1.
REQ-035 Write then read: req1 writes 0x12345678 to 0x20 -> mem_we = 1 for exactly one cycle, ack1; then req1 reads 0x20 -> rdata1 = 0x12345678.
REQ-036 Early drop: req0 pulsed for one cycle only (sampled in IDLE) -> the access still completes and ack0 pulses once; no second grant occurs.
REQ-037 Reset mid-transaction: reset asserted during ACCESS -> the next cycle has FSM = IDLE, ack0 = ack1 = 0, mem_we = 0, rdata0 = rdata1 = 0; after release, a tie is granted to requester 0.
REQ-038 Payload change: addr0 changed from 0x10 to 0x30 during ACCESS -> mem_addr stays 0x10 and the returned data is from 0x10.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each access takes three cycles: grant in IDLE, memory cycle in ACCESS, ack in RESP.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_grant;
    logic       win_id;
    logic       lat_we;
    logic       grant_id;

    // On a tie the requester not granted last wins; otherwise whoever is asking.
    always_comb begin
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (req0 || req1) ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win_id     <= 1'b0;
            lat_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= state_next;
            // mem_addr/mem_wdata double as the latched payload and hold between accesses.
            if (state == IDLE && (req0 || req1)) begin
                win_id     <= grant_id;
                last_grant <= grant_id;
                lat_we     <= grant_id ? we1 : we0;
                mem_addr   <= grant_id ? addr1 : addr0;
                mem_wdata  <= grant_id ? wdata1 : wdata0;
            end
            if (state == ACCESS && !lat_we) begin
                if (win_id) begin
                    rdata1 <= mem_rdata;
                end else begin
                    rdata0 <= mem_rdata;
                end
            end
        end
    end

    assign mem_we = (state == ACCESS) && lat_we;
    assign ack0   = (state == RESP) && !win_id;
    assign ack1   = (state == RESP) && win_id;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    logic [31:0] model_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 = free, 1 = memory cycle, 2 = response cycle.
    int          m_phase = 0;
    bit          m_win, m_we, m_last;
    logic [31:0] m_addr, m_wdata, m_rd0, m_rd1;
    bit          started = 0;

    always @(posedge clock) begin
        started = 1;
        if (reset) begin
            m_phase = 0;
            m_last  = 1;
            m_addr  = 0;
            m_wdata = 0;
            m_rd0   = 0;
            m_rd1   = 0;
        end else if (m_phase == 1) begin
            if (m_we) model_mem[m_addr[7:0]] = m_wdata;
            else if (m_win) m_rd1 = model_mem[m_addr[7:0]];
            else m_rd0 = model_mem[m_addr[7:0]];
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (req0 || req1) begin
            if (req0 && req1) m_win = !m_last;
            else m_win = req1;
            m_last  = m_win;
            m_we    = m_win ? we1 : we0;
            m_addr  = m_win ? addr1 : addr0;
            m_wdata = m_win ? wdata1 : wdata0;
            m_phase = 1;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("model_ack0", {31'b0, ack0}, {31'b0, m_phase == 2 && !m_win});
            check("model_ack1", {31'b0, ack1}, {31'b0, m_phase == 2 && m_win});
            check("model_mem_we", {31'b0, mem_we}, {31'b0, m_phase == 1 && m_we});
            check("model_mem_addr", mem_addr, m_addr);
            check("model_mem_wdata", mem_wdata, m_wdata);
            check("model_rdata0", rdata0, m_rd0);
            check("model_rdata1", rdata1, m_rd1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        mem[a]       = d;
        model_mem[a] = d;
    endtask

    int cnt;

    initial begin
        for (int i = 0; i < 256; i++) preload(i, 32'h0);
        preload(8'h04, 32'h0000_1111);
        preload(8'h08, 32'h0000_2222);
        preload(8'h10, 32'hDEAD_BEEF);
        preload(8'h30, 32'h3030_3030);
        reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        tick();
        tick();
        check("reset_ack", {30'b0, ack1, ack0}, 32'h0);
        check("reset_mem_we", {31'b0, mem_we}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_rdata0", rdata0, 32'h0);
        reset = 0;
        tick();

        // Single read
        req0 = 1; we0 = 0; addr0 = 32'h10;
        tick();
        check("read_mem_addr", mem_addr, 32'h10);
        check("read_ack_early", {30'b0, ack1, ack0}, 32'h0);
        tick();
        check("read_ack0", {30'b0, ack1, ack0}, 32'h1);
        check("read_rdata0", rdata0, 32'hDEAD_BEEF);
        req0 = 0;
        tick();
        tick();

        // Tie after reset: grants alternate 0,1,0,1 three cycles apart
        reset = 1;
        tick();
        reset = 0;
        req0 = 1; we0 = 0; addr0 = 32'h4;
        req1 = 1; we1 = 0; addr1 = 32'h8;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 2 || c == 8) check("tie_ack_grant0", {30'b0, ack1, ack0}, 32'h1);
            if (c == 5 || c == 11) check("tie_ack_grant1", {30'b0, ack1, ack0}, 32'h2);
        end
        check("tie_rdata0", rdata0, 32'h0000_1111);
        check("tie_rdata1", rdata1, 32'h0000_2222);
        req0 = 0; req1 = 0;
        tick();

        // Write then read through requester 1
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
        tick();
        check("wr_mem_we", {31'b0, mem_we}, 32'h1);
        tick();
        check("wr_ack1", {30'b0, ack1, ack0}, 32'h2);
        check("wr_mem_we_off", {31'b0, mem_we}, 32'h0);
        req1 = 0;
        tick();
        req1 = 1; we1 = 0; wdata1 = 0;
        tick();
        tick();
        check("rd_after_wr", rdata1, 32'h1234_5678);
        req1 = 0;
        tick();

        // Early drop: one-cycle request still completes exactly once
        req0 = 1; we0 = 0; addr0 = 32'h4;
        tick();
        req0 = 0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            cnt += int'(ack0);
        end
        check("early_drop_acks", cnt, 32'd1);

        // Payload change during ACCESS is ignored
        req0 = 1; we0 = 0; addr0 = 32'h10;
        tick();
        addr0 = 32'h30;
        check("payload_mem_addr", mem_addr, 32'h10);
        tick();
        check("payload_rdata0", rdata0, 32'hDEAD_BEEF);
        req0 = 0;
        tick();

        // Reset during ACCESS aborts, then a tie goes to requester 0
        req0 = 1; we0 = 0; addr0 = 32'h8;
        tick();
        reset = 1;
        tick();
        check("rst_mid_ack", {30'b0, ack1, ack0}, 32'h0);
        check("rst_mid_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mid_rdata0", rdata0, 32'h0);
        check("rst_mid_rdata1", rdata1, 32'h0);
        reset = 0;
        req1 = 1; we1 = 0; addr1 = 32'h4;
        tick();
        tick();
        check("rst_tie_ack", {30'b0, ack1, ack0}, 32'h1);
        check("rst_tie_rdata0", rdata0, 32'h0000_2222);
        req0 = 0; req1 = 0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
